// File: rtl/ltl_monitor_pkg.sv
// ltl_monitor_pkg
// Shared types for the LTL monitor engine: start-mode and config-type
// encodings, the range-entry record held per STE slot, and the range-hit
// helper used by the STE match logic.
package ltl_monitor_pkg;

  // Widest symbol a range entry can hold; engine symbols are zero-extended
  // to this width, so SYM_W must not exceed it.
  localparam int unsigned SYM_MAX_W = 16;

  typedef enum logic [1:0] {
    MODE_NONE = 2'd0,
    MODE_SOD  = 2'd1,
    MODE_ALL  = 2'd2,
    MODE_RSVD = 2'd3
  } start_mode_e;

  typedef enum logic [1:0] {
    CFG_RANGE = 2'd0,
    CFG_PRED  = 2'd1,
    CFG_MODE  = 2'd2,
    CFG_RSVD  = 2'd3
  } cfg_type_e;

  typedef struct packed {
    logic                 en;
    logic [SYM_MAX_W-1:0] lo;
    logic [SYM_MAX_W-1:0] hi;
  } range_entry_t;

  // An inverted interval (lo > hi) can never satisfy both bounds.
  function automatic logic range_hit(range_entry_t e, logic [SYM_MAX_W-1:0] s);
    return e.en && (e.lo <= s) && (s <= e.hi);
  endfunction

endpackage

// File: rtl/ltl_monitor_engine_if.sv
// ltl_monitor_engine_if
// Report channel of the LTL monitor engine.
//   rpt_valid    : head entry available (master -> slave)
//   rpt_ready    : consumer accepts head entry (slave -> master)
//   rpt_ts       : timestamp of head entry
//   rpt_vec      : report vector of head entry
//   rpt_overflow : sticky, at least one report was dropped
interface ltl_monitor_engine_if #(
  parameter int unsigned NUM_STATES = 16,
  parameter int unsigned TS_W       = 32
);
  logic                  rpt_valid;
  logic                  rpt_ready;
  logic [TS_W-1:0]       rpt_ts;
  logic [NUM_STATES-1:0] rpt_vec;
  logic                  rpt_overflow;

  modport master (
    output rpt_valid,
    output rpt_ts,
    output rpt_vec,
    output rpt_overflow,
    input  rpt_ready
  );

  modport slave (
    input  rpt_valid,
    input  rpt_ts,
    input  rpt_vec,
    input  rpt_overflow,
    output rpt_ready
  );
endinterface

// File: rtl/ltl_report_fifo.sv
// ltl_report_fifo
// Report queue for the LTL monitor engine. Entries are {ts, vec}.
//   clk, reset   : clock, synchronous active-high reset
//   push_i       : enqueue request with push_ts_i / push_vec_i
//   valid_o      : queue non-empty, head on ts_o / vec_o
//   ready_i      : consumer pops head when valid_o is high
//   overflow_o   : sticky, a push was refused
// No bypass path: a push into an empty queue shows on valid_o next cycle.
module ltl_report_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned TS_W  = 32,
  parameter int unsigned VEC_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [TS_W-1:0]  push_ts_i,
  input  logic [VEC_W-1:0] push_vec_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [TS_W-1:0]  ts_o,
  output logic [VEC_W-1:0] vec_o,
  output logic             overflow_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned ENT_W = TS_W + VEC_W;

  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             pop;
  logic             accept;

  function automatic logic [PTR_W-1:0] next_ptr(logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    pop      = (count_q != '0) && ready_i;
    // A full queue still takes a push when the head leaves the same cycle.
    accept   = push_i && ((count_q != CNT_W'(DEPTH)) || pop);
    rd_ptr_d = pop    ? next_ptr(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d = accept ? next_ptr(wr_ptr_q) : wr_ptr_q;
    count_d  = count_q;
    if (accept && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !accept) begin
      count_d = count_q - CNT_W'(1);
    end
    ovf_d    = ovf_q | (push_i & ~accept);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && accept) begin
      mem_q[wr_ptr_q] <= {push_ts_i, push_vec_i};
    end
  end

  assign valid_o       = (count_q != '0);
  assign {ts_o, vec_o} = mem_q[rd_ptr_q];
  assign overflow_o    = ovf_q;

endmodule

// File: rtl/ltl_monitor_engine.sv
// ltl_monitor_engine
// Array of state-transition elements (STEs) stepped once per qualified
// input symbol, with a timestamped report queue.
//   clk, reset       : clock, synchronous active-high reset
//   run, symbols     : symbol qualifier and current symbol
//   cfg_we/type/state/idx/wdata : configuration write port (ignored while run)
//   active           : current active-state vector
//   report           : active & report mask
//   rpt              : report channel (valid/ready, ts, vec, overflow)
module ltl_monitor_engine
  import ltl_monitor_pkg::*;
#(
  parameter int unsigned SYM_W      = 8,
  parameter int unsigned NUM_STATES = 16,
  parameter int unsigned NUM_RANGES = 4,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned TS_W       = 32,
  localparam int unsigned ST_W      = $clog2(NUM_STATES),
  localparam int unsigned IDX_W     = (NUM_RANGES > 1) ? $clog2(NUM_RANGES) : 1,
  localparam int unsigned CFG_W     = ((2 * SYM_W + 1) > NUM_STATES) ? (2 * SYM_W + 1) : NUM_STATES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic [SYM_W-1:0]      symbols,
  input  logic                  cfg_we,
  input  logic [1:0]            cfg_type,
  input  logic [ST_W-1:0]       cfg_state,
  input  logic [IDX_W-1:0]      cfg_idx,
  input  logic [CFG_W-1:0]      cfg_wdata,
  output logic [NUM_STATES-1:0] active,
  output logic [NUM_STATES-1:0] report,
  ltl_monitor_engine_if.master  rpt
);

  range_entry_t          range_q [NUM_STATES][NUM_RANGES];
  logic [NUM_STATES-1:0] pred_q  [NUM_STATES];
  start_mode_e           mode_q  [NUM_STATES];
  logic [NUM_STATES-1:0] report_mask_q;

  logic [NUM_STATES-1:0] active_q, active_d;
  logic                  sod_q;
  logic [TS_W-1:0]       ts_q;

  // Report staged one cycle behind the active update it was derived from.
  logic                  rpt_push_q;
  logic [TS_W-1:0]       rpt_ts_q;
  logic [NUM_STATES-1:0] rpt_vec_q;

  logic [NUM_STATES-1:0] ste_match;
  logic [NUM_STATES-1:0] ste_enable;
  logic [NUM_STATES-1:0] rpt_vec_d;
  logic [SYM_MAX_W-1:0]  sym_ext;

  logic                  fifo_valid;
  logic [TS_W-1:0]       fifo_ts;
  logic [NUM_STATES-1:0] fifo_vec;
  logic                  fifo_ovf;

  assign sym_ext = SYM_MAX_W'(symbols);

  always_comb begin
    ste_match  = '0;
    ste_enable = '0;
    for (int unsigned i = 0; i < NUM_STATES; i++) begin
      for (int unsigned r = 0; r < NUM_RANGES; r++) begin
        if (range_hit(range_q[i][r], sym_ext)) begin
          ste_match[i] = 1'b1;
        end
      end
      ste_enable[i] = ((mode_q[i] == MODE_SOD) && sod_q) ||
                      (mode_q[i] == MODE_ALL) ||
                      (|(active_q & pred_q[i]));
    end
    active_d  = ste_enable & ste_match;
    rpt_vec_d = active_d & report_mask_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_q      <= '0;
      sod_q         <= 1'b1;
      ts_q          <= '0;
      rpt_push_q    <= 1'b0;
      rpt_ts_q      <= '0;
      rpt_vec_q     <= '0;
      report_mask_q <= '0;
      for (int unsigned i = 0; i < NUM_STATES; i++) begin
        pred_q[i] <= '0;
        mode_q[i] <= MODE_NONE;
        for (int unsigned r = 0; r < NUM_RANGES; r++) begin
          range_q[i][r] <= '0;
        end
      end
    end else begin
      rpt_push_q <= 1'b0;
      if (run) begin
        active_q   <= active_d;
        sod_q      <= 1'b0;
        ts_q       <= ts_q + TS_W'(1);
        rpt_push_q <= |rpt_vec_d;
        rpt_ts_q   <= ts_q;
        rpt_vec_q  <= rpt_vec_d;
      end else if (cfg_we) begin
        case (cfg_type_e'(cfg_type))
          CFG_RANGE: begin
            range_q[cfg_state][cfg_idx].en <= cfg_wdata[2*SYM_W];
            range_q[cfg_state][cfg_idx].lo <= SYM_MAX_W'(cfg_wdata[2*SYM_W-1:SYM_W]);
            range_q[cfg_state][cfg_idx].hi <= SYM_MAX_W'(cfg_wdata[SYM_W-1:0]);
          end
          CFG_PRED: begin
            pred_q[cfg_state] <= cfg_wdata[NUM_STATES-1:0];
          end
          CFG_MODE: begin
            mode_q[cfg_state]        <= start_mode_e'(cfg_wdata[1:0]);
            report_mask_q[cfg_state] <= cfg_wdata[2];
          end
          default: ;
        endcase
      end
    end
  end

  ltl_report_fifo #(
    .DEPTH (FIFO_DEPTH),
    .TS_W  (TS_W),
    .VEC_W (NUM_STATES)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (rpt_push_q),
    .push_ts_i  (rpt_ts_q),
    .push_vec_i (rpt_vec_q),
    .valid_o    (fifo_valid),
    .ready_i    (rpt.rpt_ready),
    .ts_o       (fifo_ts),
    .vec_o      (fifo_vec),
    .overflow_o (fifo_ovf)
  );

  assign rpt.rpt_valid    = fifo_valid;
  assign rpt.rpt_ts       = fifo_ts;
  assign rpt.rpt_vec      = fifo_vec;
  assign rpt.rpt_overflow = fifo_ovf;

  assign active = active_q;
  assign report = active_q & report_mask_q;

endmodule

// File: tb/tb_ltl_monitor_engine.sv
module tb_ltl_monitor_engine;

  localparam int unsigned SYM_W = 8;
  localparam int unsigned NS    = 16;
  localparam int unsigned NR    = 4;
  localparam int unsigned FD    = 8;
  localparam int unsigned TSW   = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [7:0]  symbols;
  logic        cfg_we;
  logic [1:0]  cfg_type;
  logic [3:0]  cfg_state;
  logic [1:0]  cfg_idx;
  logic [16:0] cfg_wdata;
  logic [15:0] active;
  logic [15:0] report;

  ltl_monitor_engine_if #(.NUM_STATES(NS), .TS_W(TSW)) rpt_if ();

  ltl_monitor_engine #(
    .SYM_W      (SYM_W),
    .NUM_STATES (NS),
    .NUM_RANGES (NR),
    .FIFO_DEPTH (FD),
    .TS_W       (TSW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .symbols   (symbols),
    .cfg_we    (cfg_we),
    .cfg_type  (cfg_type),
    .cfg_state (cfg_state),
    .cfg_idx   (cfg_idx),
    .cfg_wdata (cfg_wdata),
    .active    (active),
    .report    (report),
    .rpt       (rpt_if)
  );

  always #5 clk = ~clk;

  // Reference model state
  typedef struct {
    logic [31:0] ts;
    logic [15:0] vec;
  } ent_t;

  bit          m_en  [16][4];
  int          m_lo  [16][4];
  int          m_hi  [16][4];
  logic [15:0] m_pred[16];
  int          m_mode[16];
  logic [15:0] m_rep;
  logic [15:0] m_active;
  bit          m_sod;
  logic [31:0] m_ts;
  ent_t        m_q[$];
  bit          m_pend;
  ent_t        m_pend_e;
  bit          m_ovf;

  int tests  = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    logic [15:0] nxt;
    bit en, hit;
    int s, st, ix;
    if (reset) begin
      m_active = '0;
      m_sod    = 1'b1;
      m_ts     = '0;
      m_q.delete();
      m_pend   = 1'b0;
      m_ovf    = 1'b0;
      m_rep    = '0;
      for (int i = 0; i < 16; i++) begin
        m_pred[i] = '0;
        m_mode[i] = 0;
        for (int r = 0; r < 4; r++) m_en[i][r] = 1'b0;
      end
      return;
    end
    if (m_q.size() > 0 && rpt_if.rpt_ready) void'(m_q.pop_front());
    if (m_pend) begin
      if (m_q.size() < FD) m_q.push_back(m_pend_e);
      else m_ovf = 1'b1;
    end
    m_pend = 1'b0;
    if (run) begin
      s   = int'(symbols);
      nxt = '0;
      for (int i = 0; i < 16; i++) begin
        en  = (m_mode[i] == 1 && m_sod) || (m_mode[i] == 2) || ((m_active & m_pred[i]) != '0);
        hit = 1'b0;
        for (int r = 0; r < 4; r++)
          if (m_en[i][r] && m_lo[i][r] <= s && s <= m_hi[i][r]) hit = 1'b1;
        nxt[i] = en && hit;
      end
      if ((nxt & m_rep) != '0) begin
        m_pend       = 1'b1;
        m_pend_e.ts  = m_ts;
        m_pend_e.vec = nxt & m_rep;
      end
      m_active = nxt;
      m_sod    = 1'b0;
      m_ts     = m_ts + 1;
    end else if (cfg_we) begin
      st = int'(cfg_state);
      ix = int'(cfg_idx);
      case (cfg_type)
        2'd0: begin
          m_en[st][ix] = cfg_wdata[16];
          m_lo[st][ix] = int'(cfg_wdata[15:8]);
          m_hi[st][ix] = int'(cfg_wdata[7:0]);
        end
        2'd1: m_pred[st] = cfg_wdata[15:0];
        2'd2: begin
          m_rep[st]  = cfg_wdata[2];
          m_mode[st] = int'(cfg_wdata[1:0]);
        end
        default: ;
      endcase
    end
  endtask

  task automatic compare_all();
    check_eq("active", 64'(active), 64'(m_active));
    check_eq("report", 64'(report), 64'(m_active & m_rep));
    check_eq("rpt_valid", 64'(rpt_if.rpt_valid), 64'(m_q.size() != 0));
    check_eq("rpt_overflow", 64'(rpt_if.rpt_overflow), 64'(m_ovf));
    if (m_q.size() != 0) begin
      check_eq("rpt_ts", 64'(rpt_if.rpt_ts), 64'(m_q[0].ts));
      check_eq("rpt_vec", 64'(rpt_if.rpt_vec), 64'(m_q[0].vec));
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    run    = 1'b0;
    cfg_we = 1'b0;
    tick();
    reset  = 1'b0;
  endtask

  task automatic cfg_wr(input logic [1:0] t, input logic [3:0] st, input logic [1:0] ix,
                        input logic [16:0] d);
    run       = 1'b0;
    cfg_we    = 1'b1;
    cfg_type  = t;
    cfg_state = st;
    cfg_idx   = ix;
    cfg_wdata = d;
    tick();
    cfg_we    = 1'b0;
  endtask

  task automatic cfg_range(input logic [3:0] st, input logic [1:0] ix, input logic [7:0] lo,
                           input logic [7:0] hi);
    cfg_wr(2'd0, st, ix, {1'b1, lo, hi});
  endtask

  task automatic cfg_mode(input logic [3:0] st, input logic rep, input logic [1:0] md);
    cfg_wr(2'd2, st, 2'd0, {14'd0, rep, md});
  endtask

  task automatic run_sym(input logic [7:0] s);
    run     = 1'b1;
    symbols = s;
    tick();
    run     = 1'b0;
  endtask

  task automatic idle(input int n);
    run = 1'b0;
    for (int k = 0; k < n; k++) begin
      symbols = 8'($urandom);
      tick();
    end
  endtask

  initial begin
    reset     = 1'b1;
    run       = 1'b0;
    symbols   = '0;
    cfg_we    = 1'b0;
    cfg_type  = '0;
    cfg_state = '0;
    cfg_idx   = '0;
    cfg_wdata = '0;
    rpt_if.rpt_ready = 1'b1;
    tick();
    do_reset();
    check_eq("rst_active", 64'(active), 64'h0);
    check_eq("rst_valid", 64'(rpt_if.rpt_valid), 64'h0);
    check_eq("rst_ovf", 64'(rpt_if.rpt_overflow), 64'h0);

    // Single range STE in all-input mode
    cfg_range(4'd0, 2'd0, 8'h10, 8'h1F);
    cfg_mode(4'd0, 1'b1, 2'd2);
    run_sym(8'h15);
    check_eq("s1_act_a", 64'(active[0]), 64'h1);
    run_sym(8'h30);
    check_eq("s1_act_b", 64'(active[0]), 64'h0);
    check_eq("s1_ts0", 64'(rpt_if.rpt_ts), 64'h0);
    run_sym(8'h1F);
    check_eq("s1_act_c", 64'(active[0]), 64'h1);
    idle(1);
    check_eq("s1_valid2", 64'(rpt_if.rpt_valid), 64'h1);
    check_eq("s1_ts2", 64'(rpt_if.rpt_ts), 64'h2);

    // Start-of-data STE feeding a successor
    do_reset();
    cfg_range(4'd0, 2'd0, 8'h00, 8'hFF);
    cfg_mode(4'd0, 1'b0, 2'd1);
    cfg_range(4'd1, 2'd0, 8'h80, 8'hFF);
    cfg_wr(2'd1, 4'd1, 2'd0, 17'h00001);
    run_sym(8'h01);
    check_eq("s2_act_a", 64'(active), 64'h1);
    run_sym(8'h90);
    check_eq("s2_act_b", 64'(active), 64'h2);
    run_sym(8'h90);
    check_eq("s2_act_c", 64'(active), 64'h0);

    // run low holds state, timestamp continues where it left off
    do_reset();
    cfg_range(4'd0, 2'd0, 8'h00, 8'hFF);
    cfg_mode(4'd0, 1'b1, 2'd2);
    run_sym(8'h05);
    run_sym(8'h05);
    idle(5);
    check_eq("s3_hold_act", 64'(active), 64'h1);
    check_eq("s3_drained", 64'(rpt_if.rpt_valid), 64'h0);
    run_sym(8'h07);
    idle(1);
    check_eq("s3_ts_cont", 64'(rpt_if.rpt_ts), 64'h2);

    // Overflow: 10 reports with no consumer
    do_reset();
    cfg_range(4'd0, 2'd0, 8'h00, 8'hFF);
    cfg_mode(4'd0, 1'b1, 2'd2);
    rpt_if.rpt_ready = 1'b0;
    for (int k = 0; k < 10; k++) run_sym(8'($urandom));
    idle(2);
    check_eq("s4_ovf", 64'(rpt_if.rpt_overflow), 64'h1);
    rpt_if.rpt_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check_eq("s4_valid", 64'(rpt_if.rpt_valid), 64'h1);
      check_eq("s4_ts", 64'(rpt_if.rpt_ts), 64'(k));
      idle(1);
    end
    check_eq("s4_empty", 64'(rpt_if.rpt_valid), 64'h0);

    // Full queue with simultaneous pop and push
    do_reset();
    cfg_range(4'd0, 2'd0, 8'h00, 8'hFF);
    cfg_mode(4'd0, 1'b1, 2'd2);
    rpt_if.rpt_ready = 1'b0;
    for (int k = 0; k < 9; k++) run_sym(8'($urandom));
    rpt_if.rpt_ready = 1'b1;
    idle(1);
    check_eq("s5_no_ovf", 64'(rpt_if.rpt_overflow), 64'h0);
    for (int k = 1; k <= 8; k++) begin
      check_eq("s5_ts", 64'(rpt_if.rpt_ts), 64'(k));
      idle(1);
    end
    check_eq("s5_empty", 64'(rpt_if.rpt_valid), 64'h0);

    // Reset with queued entries and a push in flight
    do_reset();
    cfg_range(4'd0, 2'd0, 8'h00, 8'hFF);
    cfg_mode(4'd0, 1'b1, 2'd1);
    cfg_range(4'd1, 2'd0, 8'h00, 8'hFF);
    cfg_mode(4'd1, 1'b1, 2'd2);
    rpt_if.rpt_ready = 1'b0;
    for (int k = 0; k < 4; k++) run_sym(8'($urandom));
    check_eq("s6_queued", 64'(rpt_if.rpt_valid), 64'h1);
    do_reset();
    check_eq("s6_valid", 64'(rpt_if.rpt_valid), 64'h0);
    check_eq("s6_active", 64'(active), 64'h0);
    idle(1);
    check_eq("s6_inflight", 64'(rpt_if.rpt_valid), 64'h0);
    cfg_range(4'd0, 2'd0, 8'h00, 8'hFF);
    cfg_mode(4'd0, 1'b1, 2'd1);
    run_sym(8'h42);
    check_eq("s6_sod", 64'(active), 64'h1);
    run_sym(8'h42);
    check_eq("s6_sod_gone", 64'(active), 64'h0);

    // Randomized traffic against the model
    rpt_if.rpt_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      logic [7:0] lo, hi;
      lo = 8'($urandom_range(0, 127));
      hi = lo + 8'($urandom_range(0, 128));
      cfg_wr(2'd0, 4'(i), 2'($urandom), {1'($urandom_range(0, 3) != 0), lo, hi});
      cfg_wr(2'd1, 4'(i), 2'd0, 17'($urandom) & 17'($urandom));
      cfg_wr(2'd2, 4'(i), 2'd0, 17'($urandom_range(0, 7)));
    end
    for (int c = 0; c < 800; c++) begin
      reset            = ($urandom_range(0, 299) == 0);
      run              = ($urandom_range(0, 3) != 0);
      symbols          = 8'($urandom);
      rpt_if.rpt_ready = ($urandom_range(0, 2) != 0);
      cfg_we           = ($urandom_range(0, 7) == 0);
      cfg_type         = 2'($urandom);
      cfg_state        = 4'($urandom);
      cfg_idx          = 2'($urandom);
      cfg_wdata        = 17'($urandom);
      tick();
    end
    reset  = 1'b0;
    run    = 1'b0;
    cfg_we = 1'b0;
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
